cache_mem_responder: RTL and testbench
======================================

Name: cache_mem_responder

Overview:
- Backing-memory responder on the memory side of the 2-way write-back cache.
- Serves one miss transaction at a time over a req/fill handshake:
  - an optional write-back of the evicted line to {wb_tag,index}, then
  - a refill read from {fill_tag,index}.
- Holds the full 32-entry x 3-bit main-memory image addressed by {tag,index}.

Parameters:
- TAG_W, 3, tag width
- IDX_W, 2, set index width
- DATA_W, 3, data word width
- LATENCY, 2, cycles per memory access (write or read); legal range 1..15

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  cache presents a miss transaction
- req_ready  output  1  responder can accept a transaction
- req_wb  input  1  evicted line is dirty; write-back required
- index  input  IDX_W  set index of the transaction
- wb_tag  input  TAG_W  tag of the evicted line (tag_before)
- wb_data  input  DATA_W  data of the evicted line
- fill_tag  input  TAG_W  tag being refilled
- fill_valid  output  1  fill_data is valid
- fill_ready  input  1  cache accepts the fill
- fill_data  output  DATA_W  refill word
- wb_active  output  1  write-back access in progress
- wb_count  output  8  completed write-backs, saturating at 255

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - req_ready=1, fill_valid=0, fill_data=0, wb_active=0, wb_count=0, state=IDLE, latency counter=0.
  - All 32 memory entries cleared to 0.
- Memory address is {tag,index} (TAG_W+IDX_W bits, 32 entries at defaults).
- FSM states: IDLE, WB, RD, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, capture index, wb_tag, wb_data, fill_tag and req_wb into registers.
  - Next state is WB if req_wb=1, else RD. Inputs are ignored after capture.
- WB:
  - wb_active=1 and req_ready=0.
  - The counter runs LATENCY cycles.
  - In the last cycle: mem[{wb_tag,index}] <= wb_data, wb_count increments (saturating), next state RD.
- RD:
  - Counter runs LATENCY cycles.
  - In the last cycle: fill_data <= mem[{fill_tag,index}], next state RESP.
  - The read sees any write performed in WB, so equal wb/fill addresses return the freshly written data.
- RESP:
  - fill_valid=1; fill_data is held stable until fill_ready=1.
  - On fill_valid&&fill_ready go to IDLE. fill_valid drops in the next cycle, and req_ready is 1 in that same cycle.
- Latency, counted from the accept edge = cycle 0:
  - Without write-back, fill_valid first rises in cycle LATENCY+1.
  - With write-back, fill_valid first rises in cycle 2*LATENCY+1.
- No accept occurs while not in IDLE. req_valid outside IDLE is ignored, not queued; the cache must hold it until accepted.
- fill_ready asserted outside RESP has no effect.
- Reset mid-transaction: the transaction is aborted at once.
  - A write-back not yet in its last cycle is not performed.
  - The memory image is cleared anyway.
- Width rules:
  - The latency counter is 4 bits.
  - wb_count does not wrap; it stays at 255.
- LATENCY=0 is illegal; flagged by an elaboration-time check.

Decomposition:
- Shared package cache_pkg holds:
  - TAG_W, IDX_W and DATA_W defaults
  - the derived ADDR_W = TAG_W+IDX_W
  - the responder state enum {IDLE, WB, RD, RESP}
- The cache core uses the same package, so widths match across the interface.
- One natural sub-module: mem_latency_ctr.
  - Loadable down-counter with a last-cycle pulse.
  - Reused for both the WB and RD phases.
- The memory array and FSM stay in the top.

Test Plan:
1. Reset, then read-only miss (req_wb=0, index=2, fill_tag=5; LATENCY=2) -> fill_valid rises in cycle 3, fill_data=0, wb_active never 1, wb_count=0.
2. Write-back then fill to a different address (req_wb=1, index=1, wb_tag=3, wb_data=6, fill_tag=4) -> wb_active high in cycles 1-2, wb_count=1, fill_valid in cycle 5 with fill_data=0; a following read of {3,1} returns 6.
3. Write-back and fill to the same address (index=0, wb_tag=7, wb_data=5, fill_tag=7) -> fill_data=5.
4. Backpressure: hold fill_ready=0 for 4 cycles in RESP, toggle req_valid -> fill_valid and fill_data stay stable, req_ready=0, no second accept; on fill_ready=1, IDLE follows with req_ready=1.
5. Reset asserted in WB cycle 1 of a write-back to {2,3} -> all outputs return to reset values immediately; a later read of {2,3} returns 0; wb_count=0.
6. Issue 256 write-backs -> wb_count saturates at 255 and holds.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared widths and responder state encoding for the cache/memory interface
package cache_pkg;

    localparam int CACHE_TAG_W  = 3;
    localparam int CACHE_IDX_W  = 2;
    localparam int CACHE_DATA_W = 3;
    localparam int CACHE_ADDR_W = CACHE_TAG_W + CACHE_IDX_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        RD   = 2'd2,
        RESP = 2'd3
    } resp_state_e;

endpackage

// File: rtl/mem_latency_ctr.sv
// rtl/mem_latency_ctr.sv - loadable 4-bit down-counter flagging the last cycle of a memory access
module mem_latency_ctr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_en,
    output logic       o_last
);

    logic [3:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_last = i_en && (r_cnt == 4'd0);

endmodule

// File: rtl/cache_mem_responder.sv
// rtl/cache_mem_responder.sv - backing memory serving one write-back/refill miss transaction at a time
module cache_mem_responder
    import cache_pkg::*;
#(
    parameter int TAG_W   = CACHE_TAG_W,
    parameter int IDX_W   = CACHE_IDX_W,
    parameter int DATA_W  = CACHE_DATA_W,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wb,
    input  logic [IDX_W-1:0]  index,
    input  logic [TAG_W-1:0]  wb_tag,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [TAG_W-1:0]  fill_tag,
    output logic              fill_valid,
    input  logic              fill_ready,
    output logic [DATA_W-1:0] fill_data,
    output logic              wb_active,
    output logic [7:0]        wb_count
);

    localparam int ADDR_W = TAG_W + IDX_W;
    localparam int DEPTH  = 1 << ADDR_W;

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("cache_mem_responder: LATENCY must be in 1..15");
        end
    endgenerate

    resp_state_e       r_state;
    resp_state_e       w_next;
    logic [IDX_W-1:0]  r_idx;
    logic [TAG_W-1:0]  r_wb_tag;
    logic [DATA_W-1:0] r_wb_data;
    logic [TAG_W-1:0]  r_fill_tag;
    logic [DATA_W-1:0] r_fill_data;
    logic [7:0]        r_wb_count;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_load;
    logic w_run;
    logic w_last;
    logic w_accept;

    assign w_run    = (r_state == WB) || (r_state == RD);
    assign w_accept = (r_state == IDLE) && req_valid;

    mem_latency_ctr u_lat (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (4'(LATENCY - 1)),
        .i_en       (w_run),
        .o_last     (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The counter is reloaded both on accept and on the WB->RD hand-over.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_load = 1'b1;
                    w_next = req_wb ? WB : RD;
                end
            end
            WB: begin
                if (w_last) begin
                    w_load = 1'b1;
                    w_next = RD;
                end
            end
            RD: begin
                if (w_last) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                if (fill_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_wb_tag    <= '0;
            r_wb_data   <= '0;
            r_fill_tag  <= '0;
            r_fill_data <= '0;
            r_wb_count  <= 8'd0;
        end else begin
            if (w_accept) begin
                r_idx      <= index;
                r_wb_tag   <= wb_tag;
                r_wb_data  <= wb_data;
                r_fill_tag <= fill_tag;
            end
            if ((r_state == WB) && w_last && (r_wb_count != 8'hFF)) begin
                r_wb_count <= r_wb_count + 8'd1;
            end
            if ((r_state == RD) && w_last) begin
                r_fill_data <= r_mem[{r_fill_tag, r_idx}];
            end
        end
    end

    // WB and RD occupy distinct cycles, so a same-address refill sees the fresh write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if ((r_state == WB) && w_last) begin
            r_mem[{r_wb_tag, r_idx}] <= r_wb_data;
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign fill_valid = (r_state == RESP);
    assign wb_active  = (r_state == WB);
    assign fill_data  = r_fill_data;
    assign wb_count   = r_wb_count;

endmodule

// File: tb/tb_cache_mem_responder.sv
// tb/tb_cache_mem_responder.sv - scoreboard bench for cache_mem_responder
module tb_cache_mem_responder;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_wb = 1'b0;
    logic [1:0] index = '0;
    logic [2:0] wb_tag = '0;
    logic [2:0] wb_data = '0;
    logic [2:0] fill_tag = '0;
    logic       fill_valid;
    logic       fill_ready = 1'b1;
    logic [2:0] fill_data;
    logic       wb_active;
    logic [7:0] wb_count;

    int checks = 0;
    int failures = 0;
    logic [2:0] exp_q [$];

    cache_mem_responder #(
        .TAG_W   (3),
        .IDX_W   (2),
        .DATA_W  (3),
        .LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wb     (req_wb),
        .index      (index),
        .wb_tag     (wb_tag),
        .wb_data    (wb_data),
        .fill_tag   (fill_tag),
        .fill_valid (fill_valid),
        .fill_ready (fill_ready),
        .fill_data  (fill_data),
        .wb_active  (wb_active),
        .wb_count   (wb_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && fill_valid && fill_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_fill", 1, 0);
            end else begin
                check("fill_data", int'(fill_data), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic do_txn(input logic wb, input logic [1:0] idx, input logic [2:0] wtag,
                          input logic [2:0] wdata, input logic [2:0] ftag,
                          input logic [2:0] exp_data, input int bp);
        int n;
        int wbc;
        check("req_ready_idle", int'(req_ready), 1);
        req_wb     = wb;
        index      = idx;
        wb_tag     = wtag;
        wb_data    = wdata;
        fill_tag   = ftag;
        fill_ready = (bp == 0);
        req_valid  = 1'b1;
        exp_q.push_back(exp_data);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wb_data   = ~wdata;
        fill_tag  = ~ftag;
        index     = ~idx;
        n   = 1;
        wbc = 0;
        while (!fill_valid && n < 40) begin
            if (wb_active) wbc++;
            @(posedge clk); #1;
            n++;
        end
        check("fill_latency", n, wb ? 2 * LAT + 1 : LAT + 1);
        check("wb_active_cycles", wbc, wb ? LAT : 0);
        for (int k = 0; k < bp; k++) begin
            req_valid = k[0];
            check("bp_fill_valid", int'(fill_valid), 1);
            check("bp_req_ready", int'(req_ready), 0);
            check("bp_fill_data", int'(fill_data), int'(exp_data));
            @(posedge clk); #1;
        end
        req_valid  = 1'b0;
        fill_ready = 1'b1;
        @(posedge clk); #1;
        check("post_fill_valid", int'(fill_valid), 0);
        check("post_req_ready", int'(req_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        check("rst_req_ready", int'(req_ready), 1);
        check("rst_fill_valid", int'(fill_valid), 0);
        check("rst_fill_data", int'(fill_data), 0);
        check("rst_wb_active", int'(wb_active), 0);
        check("rst_wb_count", int'(wb_count), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: read-only miss of {5,2}
        do_txn(1'b0, 2'd2, 3'd0, 3'd0, 3'd5, 3'd0, 0);
        check("t1_wb_count", int'(wb_count), 0);

        // 2: write-back 6 to {3,1}, refill from {4,1}, then read back {3,1}
        do_txn(1'b1, 2'd1, 3'd3, 3'd6, 3'd4, 3'd0, 0);
        check("t2_wb_count", int'(wb_count), 1);
        do_txn(1'b0, 2'd1, 3'd0, 3'd0, 3'd3, 3'd6, 0);

        // 3: write-back and refill of the same address {7,0}
        do_txn(1'b1, 2'd0, 3'd7, 3'd5, 3'd7, 3'd5, 0);
        check("t3_wb_count", int'(wb_count), 2);

        // 4: backpressure in RESP for 4 cycles while req_valid toggles
        do_txn(1'b0, 2'd0, 3'd0, 3'd0, 3'd7, 3'd5, 4);
        @(posedge clk); #1;
        check("t4_idle_hold", int'(req_ready), 1);

        // 5: reset during the first WB cycle of a write-back to {2,3}
        req_wb    = 1'b1;
        index     = 2'd3;
        wb_tag    = 3'd2;
        wb_data   = 3'd7;
        fill_tag  = 3'd2;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("t5_in_wb", int'(wb_active), 1);
        rst_n = 1'b0;
        #1;
        check("t5_req_ready", int'(req_ready), 1);
        check("t5_fill_valid", int'(fill_valid), 0);
        check("t5_fill_data", int'(fill_data), 0);
        check("t5_wb_active", int'(wb_active), 0);
        check("t5_wb_count", int'(wb_count), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_txn(1'b0, 2'd3, 3'd0, 3'd0, 3'd2, 3'd0, 0);
        do_txn(1'b0, 2'd1, 3'd0, 3'd0, 3'd3, 3'd0, 0);
        check("t5_wb_count_after", int'(wb_count), 0);

        // 6: 256 write-backs, each refilling its own freshly written word
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'(i);
            do_txn(1'b1, v[1:0], v[4:2], v[2:0], v[4:2], v[2:0], 0);
            if (i == 0) check("t6_count_first", int'(wb_count), 1);
            if (i == 254) check("t6_count_255", int'(wb_count), 255);
        end
        check("t6_count_sat", int'(wb_count), 255);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
